// File: rtl/lc3_mem_access.sv
// Memory-side sequencer for the LC-3 datapath: one SRAM read or write per Start,
// strobes held for WAIT_CYCLES cycles, then a single-cycle ready pulse R.
module lc3_mem_access #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Rd_nWr,
    input  logic [15:0] Addr,
    input  logic [15:0] Wr_Data,
    input  logic [15:0] Mem_Data_In,
    output logic [15:0] Mem_Addr,
    output logic [15:0] Mem_Data_Out,
    output logic        Mem_CE,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [15:0] MDR_Data,
    output logic        Busy,
    output logic        R
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e     state;
    logic [3:0] wait_cnt;
    logic       op_read;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= StIdle;
            wait_cnt     <= 4'd0;
            op_read      <= 1'b0;
            Mem_Addr     <= 16'h0000;
            Mem_Data_Out <= 16'h0000;
            Mem_CE       <= 1'b0;
            Mem_OE       <= 1'b0;
            Mem_WE       <= 1'b0;
            MDR_Data     <= 16'h0000;
            Busy         <= 1'b0;
            R            <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (Start) begin
                        Mem_Addr     <= Addr;
                        Mem_Data_Out <= Wr_Data;
                        op_read      <= Rd_nWr;
                        wait_cnt     <= 4'(WAIT_CYCLES - 1);
                        Mem_CE       <= 1'b1;
                        Mem_OE       <= Rd_nWr;
                        Mem_WE       <= ~Rd_nWr;
                        Busy         <= 1'b1;
                        state        <= StAccess;
                    end
                end
                StAccess: begin
                    // The count loaded at Start is WAIT_CYCLES-1, so zero marks the last cycle.
                    if (wait_cnt == 4'd0) begin
                        Mem_CE <= 1'b0;
                        Mem_OE <= 1'b0;
                        Mem_WE <= 1'b0;
                        R      <= 1'b1;
                        if (op_read) begin
                            MDR_Data <= Mem_Data_In;
                        end
                        state <= StDone;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                StDone: begin
                    R     <= 1'b0;
                    Busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_access.sv
// Directed self-checking bench for lc3_mem_access: W=2 main instance plus W=1 and W=15
// instances for the latency boundaries.
module tb_lc3_mem_access;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start, start1, start15;
    logic        Rd_nWr;
    logic [15:0] Addr, Wr_Data, Mem_Data_In;

    logic [15:0] mem_addr, mem_data_out, mdr_data;
    logic        mem_ce, mem_oe, mem_we, busy, r;

    logic [15:0] mem_addr1, mem_data_out1, mdr_data1;
    logic        mem_ce1, mem_oe1, mem_we1, busy1, r1;

    logic [15:0] mem_addr15, mem_data_out15, mdr_data15;
    logic        mem_ce15, mem_oe15, mem_we15, busy15, r15;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    lc3_mem_access #(.WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Rd_nWr(Rd_nWr), .Addr(Addr),
        .Wr_Data(Wr_Data), .Mem_Data_In(Mem_Data_In), .Mem_Addr(mem_addr),
        .Mem_Data_Out(mem_data_out), .Mem_CE(mem_ce), .Mem_OE(mem_oe), .Mem_WE(mem_we),
        .MDR_Data(mdr_data), .Busy(busy), .R(r)
    );

    lc3_mem_access #(.WAIT_CYCLES(1)) dut_w1 (
        .Clk(Clk), .Reset(Reset), .Start(start1), .Rd_nWr(Rd_nWr), .Addr(Addr),
        .Wr_Data(Wr_Data), .Mem_Data_In(Mem_Data_In), .Mem_Addr(mem_addr1),
        .Mem_Data_Out(mem_data_out1), .Mem_CE(mem_ce1), .Mem_OE(mem_oe1), .Mem_WE(mem_we1),
        .MDR_Data(mdr_data1), .Busy(busy1), .R(r1)
    );

    lc3_mem_access #(.WAIT_CYCLES(15)) dut_w15 (
        .Clk(Clk), .Reset(Reset), .Start(start15), .Rd_nWr(Rd_nWr), .Addr(Addr),
        .Wr_Data(Wr_Data), .Mem_Data_In(Mem_Data_In), .Mem_Addr(mem_addr15),
        .Mem_Data_Out(mem_data_out15), .Mem_CE(mem_ce15), .Mem_OE(mem_oe15), .Mem_WE(mem_we15),
        .MDR_Data(mdr_data15), .Busy(busy15), .R(r15)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Outputs are registered, so #1 after the edge they are settled.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Strobe/status vector: {CE, OE, WE, Busy, R}
    function automatic logic [4:0] flags();
        return {mem_ce, mem_oe, mem_we, busy, r};
    endfunction

    task automatic access(input string tag, input logic rd, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] sram,
                          input logic [15:0] exp_mdr);
        Rd_nWr      = rd;
        Addr        = a;
        Wr_Data     = wd;
        Mem_Data_In = sram;
        Start       = 1'b1;
        tick();
        Start = 1'b0;
        for (int n = 1; n <= W; n++) begin
            check({tag, "_access_flags"}, 32'(flags()), 32'({1'b1, rd, ~rd, 1'b1, 1'b0}));
            check({tag, "_access_addr"}, 32'(mem_addr), 32'(a));
            check({tag, "_access_wdata"}, 32'(mem_data_out), 32'(wd));
            if (n < W) tick();
        end
        tick();
        check({tag, "_done_flags"}, 32'(flags()), 32'(5'b00011));
        check({tag, "_done_mdr"}, 32'(mdr_data), 32'(exp_mdr));
        tick();
        check({tag, "_idle_flags"}, 32'(flags()), 32'(5'b00000));
        check({tag, "_idle_addr_hold"}, 32'(mem_addr), 32'(a));
        check({tag, "_idle_mdr_hold"}, 32'(mdr_data), 32'(exp_mdr));
    endtask

    initial begin
        int r_cnt;
        int r_at1, r_at15, ce_cnt1, ce_cnt15;

        Reset = 1'b1; Start = 1'b0; start1 = 1'b0; start15 = 1'b0;
        Rd_nWr = 1'b0; Addr = 16'h0; Wr_Data = 16'h0; Mem_Data_In = 16'h0;
        tick();
        tick();
        Reset = 1'b0;
        check("reset_flags", 32'(flags()), 32'(5'b00000));
        check("reset_addr", 32'(mem_addr), 32'h0);
        check("reset_wdata", 32'(mem_data_out), 32'h0);
        check("reset_mdr", 32'(mdr_data), 32'h0);

        access("read", 1'b1, 16'h3000, 16'h0000, 16'h1234, 16'h1234);
        access("write", 1'b0, 16'h3001, 16'hBEEF, 16'h9999, 16'h1234);

        // Start and a new address presented throughout ACCESS and DONE must be ignored.
        Rd_nWr = 1'b1; Addr = 16'h3000; Mem_Data_In = 16'h5555; Start = 1'b1;
        tick();
        Addr  = 16'h4000;
        r_cnt = 0;
        for (int n = 1; n <= 8; n++) begin
            if (n == 4) Start = 1'b0;
            if (r) r_cnt++;
            check("ignore_addr", 32'(mem_addr), 32'h3000);
            tick();
        end
        check("ignore_r_count", 32'(r_cnt), 32'd1);
        check("ignore_mdr", 32'(mdr_data), 32'h5555);

        // Reset during the first ACCESS cycle aborts the read.
        Rd_nWr = 1'b1; Addr = 16'h3000; Mem_Data_In = 16'h7777; Start = 1'b1;
        tick();
        Start = 1'b0;
        check("abort_in_access", 32'(flags()), 32'(5'b11010));
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort_flags", 32'(flags()), 32'(5'b00000));
        check("abort_addr", 32'(mem_addr), 32'h0);
        check("abort_wdata", 32'(mem_data_out), 32'h0);
        check("abort_mdr", 32'(mdr_data), 32'h0);
        r_cnt = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (r) r_cnt++;
        end
        check("abort_no_r", 32'(r_cnt), 32'd0);

        // Start held high: back-to-back reads every W+2 cycles.
        Rd_nWr = 1'b1; Addr = 16'h3100; Mem_Data_In = 16'hA000; Start = 1'b1;
        r_cnt = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            Mem_Data_In = 16'hA000 + 16'(n / 4);
            if (r) r_cnt++;
            check("stream_r", 32'(r), 32'((n % 4) == 3));
            if ((n % 4) == 3) check("stream_mdr", 32'(mdr_data), 32'(16'hA000 + 16'(n / 4)));
        end
        Start = 1'b0;
        check("stream_r_count", 32'(r_cnt), 32'd3);
        tick();
        check("stream_end_idle", 32'(flags()), 32'(5'b00000));

        // Latency boundaries on the W=1 and W=15 instances.
        Rd_nWr = 1'b1; Addr = 16'h3200; Mem_Data_In = 16'hC0DE;
        start1 = 1'b1; start15 = 1'b1;
        tick();
        start1 = 1'b0; start15 = 1'b0;
        r_at1 = 0; r_at15 = 0; ce_cnt1 = 0; ce_cnt15 = 0;
        for (int n = 1; n <= 20; n++) begin
            if (r1 && r_at1 == 0) r_at1 = n;
            if (r15 && r_at15 == 0) r_at15 = n;
            if (mem_ce1) ce_cnt1++;
            if (mem_ce15) ce_cnt15++;
            tick();
        end
        check("w1_r_cycle", 32'(r_at1), 32'd2);
        check("w1_ce_cycles", 32'(ce_cnt1), 32'd1);
        check("w1_mdr", 32'(mdr_data1), 32'hC0DE);
        check("w15_r_cycle", 32'(r_at15), 32'd16);
        check("w15_ce_cycles", 32'(ce_cnt15), 32'd15);
        check("w15_mdr", 32'(mdr_data15), 32'hC0DE);
        check("w15_idle", 32'(busy15), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
